uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter that accepts bytes over a valid/ready handshake into an internal FIFO and serialises them with configurable data width, parity and stop-bit count. It is the next-generation transmit path for the FPGA's debug/console UART. It replaces single-shot, one-byte transmission with buffered, back-to-back framing, so upstream logic can burst data without polling.

## Interface
- CLK, 200_000_000, system clock frequency in Hz
- BPS, 115200, baud rate; bit period BPS_CNT = CLK/BPS cycles (integer truncation), BPS_CNT >= 4
- DATA_BITS, 8, data bits per frame, legal 5..8
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 16, entries, power of two, 2..256

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- tx_valid  in  1  upstream word valid
- tx_ready  out  1  FIFO can accept (= !full)
- tx_data  in  DATA_BITS  word to send, LSB transmitted first
- tx_pin  out  1  serial line, idle high, registered
- busy  out  1  FSM not in IDLE
- fifo_level  out  $clog2(FIFO_DEPTH+1)  words stored, excluding the frame in flight

## Operation
- Write: tx_valid && tx_ready at a rising edge pushes tx_data. With tx_ready low, tx_data is ignored; upstream holds it.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: tx_pin = 1. If FIFO is non-empty, pop the head into the shift register and enter START.
- START: tx_pin = 0 for BPS_CNT cycles, then go to DATA.
- DATA: DATA_BITS bits, LSB first, each BPS_CNT cycles. Then go to PAR if PARITY != 0, else STOP.
- PAR: even parity bit = XOR of the data bits; odd parity bit = its inverse. Held BPS_CNT cycles.
- STOP: tx_pin = 1 for STOP_BITS*BPS_CNT cycles.
  - On the final cycle of STOP, if the FIFO is non-empty, pop and go directly to START. No idle gap between frames.
  - Otherwise go to IDLE.
- Baud counter width is $clog2(BPS_CNT). It resets to 0 on every state entry and wraps at BPS_CNT-1. The bit counter is $clog2(DATA_BITS+1) wide.
- Simultaneous push and pop: level is unchanged, and both operations complete.
- Push when full: impossible, since tx_ready = 0. Pop when empty: never occurs.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty is derived from fifo_level.

## Timing
- Reset (rst = 0 at an edge) forces the following on that edge:
  - tx_pin = 1, busy = 0, fifo_level = 0, tx_ready = 1
  - FSM = IDLE; pointers and counters = 0
- Reset mid-frame aborts the frame immediately and flushes the FIFO. No partial frame resumes after release.
- Latency from IDLE: a word accepted at edge N is popped at edge N+1. tx_pin falls and busy rises after edge N+1.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BPS_CNT cycles exactly.
- Back-to-back frames have the same period, with no extra cycles.
- busy falls on the edge ending the final stop bit when the FIFO is empty.
- tx_ready and fifo_level are registered. They reflect pushes and pops from the previous edge.

## Test plan
- Basic 8N1 frame: CLK=1000, BPS=100 (BPS_CNT=10), write 0xA5 once while idle.
  - tx_pin: low for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles.
  - busy is high for exactly 100 cycles. fifo_level returns to 0.
- Parity: 8E1, send 0x07 -> parity bit 1. 8O1, send 0x07 -> parity bit 0. 8E1, send 0x00 -> parity bit 0. Frame is 110 cycles.
- FIFO fill: FIFO_DEPTH=4, tx_valid held high from idle with 0x10, 0x11, ...
  - Exactly 5 words are accepted on consecutive edges (the first is popped immediately).
  - tx_ready goes low with fifo_level = 4.
  - The 6th word is accepted one cycle after the first frame's last stop-bit edge pops the next word.
- Back-to-back streaming: queue 3 words in 8N1.
  - The stop-bit high lasts exactly 10 cycles between frames.
  - Start edges are 100 cycles apart; 300 cycles total.
  - Output bit sequence matches the inputs in order.
- Width and stop bits: DATA_BITS=7, STOP_BITS=2, PARITY=2, send 0x7F.
  - 7 ones, then parity 1, then 20 high cycles; frame is 110 cycles.
- Reset mid-frame: assert rst during data bit 3 with 2 words queued.
  - Next edge: tx_pin = 1, busy = 0, fifo_level = 0, tx_ready = 1.
  - After release, the line stays idle high with no further frames.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Buffered UART transmitter: a valid/ready write port fills a FIFO that the
// framing FSM drains onto tx_pin with no idle gap between queued frames.
module uart_tx_frame #(
  parameter int CLK        = 200_000_000,
  parameter int BPS        = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  input  logic [DATA_BITS-1:0]            tx_data,
  output logic                            tx_pin,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int BPS_CNT = CLK / BPS;
  localparam int BAUD_W  = $clog2(BPS_CNT);
  localparam int BIT_W   = $clog2(DATA_BITS + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_CNT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // Parity is fixed when the word is popped, before the shifter destroys it.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ready_q, ready_d;

  logic [2:0]           state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_pin_q, tx_pin_d;

  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 baud_end;
  logic [DATA_BITS-1:0] head;

  assign push       = tx_valid && ready_q;
  assign fifo_empty = (level_q == '0);
  assign baud_end   = (baud_q == BAUD_LAST);
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    ready_d  = (level_d != LVL_FULL);
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    baud_d   = baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    tx_pin_d = tx_pin_q;
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d   = '0;
        tx_pin_d = 1'b1;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shreg_d  = head;
          par_d    = parity_bit(head);
          bit_d    = '0;
          state_d  = ST_START;
          tx_pin_d = 1'b0;
        end
      end

      ST_START: begin
        if (baud_end) begin
          baud_d   = '0;
          bit_d    = '0;
          state_d  = ST_DATA;
          tx_pin_d = shreg_q[0];
        end
      end

      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d  = ST_PAR;
              tx_pin_d = par_q;
            end else begin
              state_d  = ST_STOP;
              tx_pin_d = 1'b1;
            end
          end else begin
            shreg_d  = {1'b0, shreg_q[DATA_BITS-1:1]};
            bit_d    = bit_q + BIT_W'(1);
            tx_pin_d = shreg_q[1];
          end
        end
      end

      ST_PAR: begin
        if (baud_end) begin
          baud_d   = '0;
          bit_d    = '0;
          state_d  = ST_STOP;
          tx_pin_d = 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + BIT_W'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit to keep frames gapless.
            pop      = 1'b1;
            shreg_d  = head;
            par_d    = parity_bit(head);
            bit_d    = '0;
            state_d  = ST_START;
            tx_pin_d = 1'b0;
          end else begin
            bit_d    = '0;
            state_d  = ST_IDLE;
            tx_pin_d = 1'b1;
          end
        end
      end

      default: begin
        baud_d   = '0;
        bit_d    = '0;
        state_d  = ST_IDLE;
        tx_pin_d = 1'b1;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tx_pin_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tx_pin_q <= tx_pin_d;
    end
  end

  // NOTE: the storage array has no reset; zeroed pointers and level make any
  // stale contents unreachable, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= tx_data;
    end
  end

  assign tx_ready   = ready_q;
  assign tx_pin     = tx_pin_q;
  assign busy       = (state_q != ST_IDLE);
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four instances (8N1, 8E1, 8O1, 7E2) at
// BPS_CNT = 10, FIFO depth 4, checked cycle-by-cycle against a frame model.
module tb_uart_tx_frame;

  localparam int NCFG = 4;
  localparam int BPSC = 10;
  localparam int DB_C  [NCFG] = '{8, 8, 8, 7};
  localparam int PAR_C [NCFG] = '{0, 2, 1, 2};
  localparam int SB_C  [NCFG] = '{1, 1, 1, 2};

  logic             clk = 1'b0;
  logic             rst;
  logic [NCFG-1:0]  v;
  logic [NCFG-1:0]  rdy;
  logic [NCFG-1:0]  pin;
  logic [NCFG-1:0]  busy;
  logic [7:0]       data [NCFG];
  logic [2:0]       lvl  [NCFG];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int DB = DB_C[g];
    uart_tx_frame #(
      .CLK(1000), .BPS(100), .DATA_BITS(DB), .PARITY(PAR_C[g]),
      .STOP_BITS(SB_C[g]), .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk), .rst(rst), .tx_valid(v[g]), .tx_ready(rdy[g]),
      .tx_data(data[g][DB-1:0]), .tx_pin(pin[g]), .busy(busy[g]),
      .fifo_level(lvl[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: bit-period k of the line carries f[k].
  function automatic logic [15:0] frame_bits(input int db, input int par, input logic [7:0] w);
    logic [15:0] f = '1;
    int ones = 0;
    f[0] = 1'b0;
    for (int k = 0; k < db; k++) begin
      f[1+k] = w[k];
      if (w[k]) ones++;
    end
    if (par == 2) f[1+db] = (ones % 2 == 1);
    else if (par == 1) f[1+db] = (ones % 2 == 0);
    return f;
  endfunction

  function automatic int flen(input int i);
    return (1 + DB_C[i] + ((PAR_C[i] != 0) ? 1 : 0) + SB_C[i]) * BPSC;
  endfunction

  // Scoreboard state
  logic [7:0]  exp_q   [NCFG][$];
  int          start_q [NCFG][$];
  int          pos     [NCFG] = '{default: -1};
  int          bad     [NCFG];
  logic [15:0] fbits   [NCFG];
  int          busy_cnt[NCFG] = '{default: 0};
  logic        rdy_s   [NCFG] = '{default: 1'b0};
  logic        rst_edge = 1'b0;
  int          cyc = 0;

  // Accepted words enter the expected queue; a reset edge flushes it.
  always @(posedge clk) begin
    rst_edge <= rst;
    for (int i = 0; i < NCFG; i++) begin
      if (!rst) exp_q[i].delete();
      else if (v[i] && rdy_s[i]) exp_q[i].push_back(data[i]);
    end
  end

  // Monitor: a falling line starts a frame, compared every cycle to the model.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NCFG; i++) begin
      rdy_s[i] = rdy[i];
      if (busy[i]) busy_cnt[i]++;
      if (!rst_edge) begin
        pos[i] = -1;
      end else begin
        if (pos[i] == -1 && pin[i] == 1'b0) begin
          check($sformatf("u%0d_word_queued_at_start", i), exp_q[i].size() != 0, 1);
          if (exp_q[i].size() != 0) begin
            fbits[i] = frame_bits(DB_C[i], PAR_C[i], exp_q[i].pop_front());
            pos[i] = 0;
            bad[i] = 0;
            start_q[i].push_back(cyc);
          end else begin
            pos[i] = -2;
          end
        end else if (pos[i] == -2 && pin[i] == 1'b1) begin
          pos[i] = -1;
        end
        if (pos[i] >= 0) begin
          if (pin[i] !== fbits[i][pos[i] / BPSC]) bad[i]++;
          pos[i]++;
          if (pos[i] == flen(i)) begin
            check($sformatf("u%0d_frame_bad_cycles", i), bad[i], 0);
            pos[i] = -1;
          end
        end
      end
    end
  end

  task automatic send(input int i, input logic [7:0] w);
    int n = 0;
    @(negedge clk);
    v[i] = 1'b1;
    data[i] = w;
    while (!rdy[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d_send_ready_timeout", i), rdy[i], 1);
    @(negedge clk);
    v[i] = 1'b0;
  endtask

  task automatic measure(input int i, input int idx, output logic bv, output int len);
    int n = 0;
    bv = 1'bx;
    for (int t = 0; t < 2000; t++) begin
      if (busy[i]) begin
        if (n == idx * BPSC + 5) bv = pin[i];
        n++;
      end else if (n > 0) begin
        break;
      end
      @(negedge clk);
    end
    len = n;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int t = 0;
    while ((busy[i] || lvl[i] != 0 || pos[i] >= 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("u%0d_drain_timeout", i), t < budget, 1);
  endtask

  task automatic check_gaps(input string name, input int i, input int s0, input int n);
    check({name, "_frames"}, start_q[i].size(), s0 + n);
    for (int k = s0 + 1; k < s0 + n && k < start_q[i].size(); k++)
      check($sformatf("%s_gap%0d", name, k - s0), start_q[i][k] - start_q[i][k-1], 100);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic bv;
    int   len, s0, b0, acc, blk, blk_lvl, lows, highs, t;
    int   acc_at [6];
    int   sent   [NCFG];
    logic [NCFG-1:0] was_rdy;

    rst = 1'b0;
    v   = '0;
    for (int i = 0; i < NCFG; i++) data[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("u%0d_rst_pin", i), pin[i], 1);
      check($sformatf("u%0d_rst_busy", i), busy[i], 0);
      check($sformatf("u%0d_rst_level", i), lvl[i], 0);
      check($sformatf("u%0d_rst_ready", i), rdy[i], 1);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 8N1 0xA5: one-cycle pop latency, 100-cycle busy window.
    send(0, 8'hA5);
    check("basic_busy_before_pop", busy[0], 0);
    check("basic_level_before_pop", lvl[0], 1);
    @(negedge clk);
    check("basic_pin_start", pin[0], 0);
    check("basic_busy_after_pop", busy[0], 1);
    check("basic_level_after_pop", lvl[0], 0);
    measure(0, 4, bv, len);
    check("basic_data_bit3", bv, 0);
    check("basic_busy_len", len, 100);
    check("basic_level_end", lvl[0], 0);
    check("basic_pin_end", pin[0], 1);

    // Parity
    send(1, 8'h07); measure(1, 9, bv, len);
    check("par_8e1_07_bit", bv, 1);
    check("par_8e1_len", len, 110);
    send(2, 8'h07); measure(2, 9, bv, len);
    check("par_8o1_07_bit", bv, 0);
    check("par_8o1_len", len, 110);
    send(1, 8'h00); measure(1, 9, bv, len);
    check("par_8e1_00_bit", bv, 0);

    // 7E2 with 0x7F
    send(3, 8'h7F); measure(3, 8, bv, len);
    check("w7e2_par_bit", bv, 1);
    check("w7e2_len", len, 110);

    // FIFO fill: valid held high from idle on the depth-4 8N1 instance.
    s0 = start_q[0].size();
    acc = 0; blk = -1; blk_lvl = -1; t = 0;
    @(negedge clk);
    v[0] = 1'b1;
    data[0] = 8'h10;
    while (acc < 6 && t < 400) begin
      if (rdy[0]) begin
        acc_at[acc] = t;
        acc++;
        @(negedge clk);
        data[0] = data[0] + 8'h01;
      end else begin
        if (blk < 0) begin
          blk = t;
          blk_lvl = int'(lvl[0]);
        end
        @(negedge clk);
      end
      t++;
    end
    v[0] = 1'b0;
    check("fill_accepted", acc, 6);
    check("fill_first5_consecutive", acc_at[4] - acc_at[0], 4);
    check("fill_block_cycle", blk, 5);
    check("fill_block_level", blk_lvl, 4);
    check("fill_sixth_accept", acc_at[5], 102);
    wait_idle(0, 1000);
    check_gaps("fill", 0, s0, 6);

    // Back-to-back: three random words, 300 busy cycles.
    s0 = start_q[0].size();
    b0 = busy_cnt[0];
    for (int k = 0; k < 3; k++) send(0, 8'($urandom));
    wait_idle(0, 1000);
    check_gaps("b2b", 0, s0, 3);
    check("b2b_busy_total", busy_cnt[0] - b0, 300);

    // Randomized traffic on all instances at once.
    for (int i = 0; i < NCFG; i++) sent[i] = 0;
    was_rdy = '0;
    t = 0;
    while ((sent[0] < 20 || sent[1] < 20 || sent[2] < 20 || sent[3] < 20) && t < 15000) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < NCFG; i++) begin
        if (v[i] && was_rdy[i]) begin
          v[i] = 1'b0;
          sent[i]++;
        end
        if (!v[i] && sent[i] < 20 && $urandom_range(0, 5) == 0) begin
          v[i] = 1'b1;
          data[i] = 8'($urandom);
        end
        was_rdy[i] = rdy[i];
      end
    end
    check("rand_all_sent", t < 15000, 1);
    for (int i = 0; i < NCFG; i++) wait_idle(i, 3000);

    // Reset during data bit 3 with two words still queued.
    s0 = start_q[0].size();
    for (int k = 0; k < 3; k++) send(0, 8'($urandom));
    check("rst_frame_started", start_q[0].size(), s0 + 1);
    t = 0;
    while (start_q[0].size() > s0 && cyc < start_q[0][s0] + 44 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rst_level_before", lvl[0], 2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_pin", pin[0], 1);
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_level", lvl[0], 0);
    check("rst_mid_ready", rdy[0], 1);
    rst = 1'b1;
    lows = 0; highs = 0;
    repeat (300) begin
      @(negedge clk);
      if (!pin[0]) lows++;
      if (busy[0]) highs++;
    end
    check("rst_after_pin_low_cycles", lows, 0);
    check("rst_after_busy_cycles", highs, 0);
    check("rst_after_no_new_frames", start_q[0].size(), s0 + 1);

    for (int i = 0; i < NCFG; i++)
      check($sformatf("u%0d_scoreboard_empty", i), exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
